// File: rtl/ram8_rdport_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram8_rdport_pkg
// Brief    : Shared sizing defaults and word type for the ALU, register file
//            and ram8_rdport storage.
// Revision : 1.0 - initial release
// ============================================================================
package ram8_rdport_pkg;

  localparam int DATA_W    = 16;
  localparam int MEM_DEPTH = 8;
  localparam int ADDR_W    = $clog2(MEM_DEPTH);

  typedef logic [DATA_W-1:0] word_t;

endpackage
`default_nettype wire

// File: rtl/ram8_word.sv
`default_nettype none
// ============================================================================
// Module   : ram8_word
// Brief    : One resettable storage word with a load enable.
// Revision : 1.0 - initial release
// ============================================================================
module ram8_word #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram8_rdport.sv
`default_nettype none
// ============================================================================
// Module   : ram8_rdport
// Brief    : DEPTH x WIDTH synchronous memory, plain write port and a
//            valid/ready handshaked read port with a one-entry response reg.
//            Define RAM8_BYPASS_EN for write-first same-address forwarding;
//            otherwise a colliding read returns the pre-write contents.
// Revision : 1.0 - initial release
// ============================================================================
module ram8_rdport
  import ram8_rdport_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = MEM_DEPTH,
  parameter int AW    = ADDR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [AW-1:0]    address,
  input  logic [WIDTH-1:0] in,
  input  logic             rd_req,
  input  logic [AW-1:0]    rd_addr,
  output logic             rd_gnt,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] words [DEPTH];
  logic [WIDTH-1:0] rd_word;
  logic             rd_accept;

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
      logic word_load;
      assign word_load = load && (address == AW'(i));

      ram8_word #(
        .WIDTH (WIDTH)
      ) u_word (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (word_load),
        .d     (in),
        .q     (words[i])
      );
    end
  endgenerate

`ifdef RAM8_BYPASS_EN
  assign rd_word = (load && (address == rd_addr)) ? in : words[rd_addr];
`else
  assign rd_word = words[rd_addr];
`endif

  assign rd_gnt    = !rd_valid || rd_ready;
  assign rd_accept = rd_req && rd_gnt;

  // A held response is a snapshot: it only changes on a new accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (rd_accept) begin
      rd_valid <= 1'b1;
      rd_data  <= rd_word;
    end else if (rd_ready) begin
      rd_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire
